// File: rtl/regfile_mp.sv
// Multi-port integer register file with a pending-write scoreboard and a sequential clear engine.
// Optional write-to-read bypass in IDLE: define REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int REGIDX_WIDTH = $clog2(NUM_REGS),
    parameter int NUM_RD       = 2,
    parameter int NUM_WR       = 1,
    parameter int ZERO_REG     = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_RD*REGIDX_WIDTH-1:0] i_rs_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   o_rs_data,
    output logic [NUM_RD-1:0]              o_rs_busy,
    input  logic [NUM_WR-1:0]              i_rd_wen,
    input  logic [NUM_WR*REGIDX_WIDTH-1:0] i_rd_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   i_rd_data,
    input  logic                           i_sb_set,
    input  logic [REGIDX_WIDTH-1:0]        i_sb_addr,
    input  logic                           i_clr_req,
    output logic                           o_clr_busy
);
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                                state_q;
    logic [REGIDX_WIDTH-1:0]               cnt_q;
    logic                                  clr_busy_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   regs_q, regs_d;
    logic [NUM_REGS-1:0]                   busy_q, busy_d;

    logic                                  idle;
    logic [NUM_WR-1:0]                     wen_eff;
    logic [REGIDX_WIDTH-1:0]               wr_addr [NUM_WR];
    logic [DATA_WIDTH-1:0]                 wr_data [NUM_WR];
    logic                                  sb_eff;

    // Out-of-range indices only exist when NUM_REGS is not a power of two.
    function automatic logic addr_ok(input logic [REGIDX_WIDTH-1:0] a);
        return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign idle       = (state_q == S_IDLE);
    assign o_clr_busy = clr_busy_q;
    assign sb_eff     = idle && i_sb_set && addr_ok(i_sb_addr);

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        assign wr_addr[w] = i_rd_addr[w*REGIDX_WIDTH +: REGIDX_WIDTH];
        assign wr_data[w] = i_rd_data[w*DATA_WIDTH +: DATA_WIDTH];
        assign wen_eff[w] = idle && i_rd_wen[w] && addr_ok(wr_addr[w]);
    end

    // Ascending port order makes the highest-index writer win; the scoreboard set
    // is applied after the write-backs so a new producer supersedes the old one.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (state_q == S_CLEAR) begin
            regs_d[cnt_q] = '0;
            busy_d[cnt_q] = 1'b0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wen_eff[w]) begin
                    regs_d[wr_addr[w]] = wr_data[w];
                    busy_d[wr_addr[w]] = 1'b0;
                end
            end
            if (sb_eff) busy_d[i_sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (i_clr_req) begin
                    state_q    <= S_CLEAR;
                    cnt_q      <= (ZERO_REG != 0) ? REGIDX_WIDTH'(1) : '0;
                    clr_busy_q <= 1'b1;
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + REGIDX_WIDTH'(1);
                    if (cnt_q == REGIDX_WIDTH'(NUM_REGS - 1)) begin
                        state_q    <= S_IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Read ports; outputs are forced to zero while reset is held.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [REGIDX_WIDTH-1:0] rs_a;
        logic [DATA_WIDTH-1:0]   rs_d;
        logic                    rs_b;

        assign rs_a = i_rs_addr[k*REGIDX_WIDTH +: REGIDX_WIDTH];

        always_comb begin
            rs_d = '0;
            rs_b = 1'b0;
            if (i_rst_n && addr_ok(rs_a)) begin
                rs_d = regs_q[rs_a];
                rs_b = busy_q[rs_a];
`ifdef REGFILE_MP_BYPASS_EN
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wen_eff[w] && (wr_addr[w] == rs_a)) rs_d = wr_data[w];
                end
`endif
            end
        end

        assign o_rs_data[k*DATA_WIDTH +: DATA_WIDTH] = rs_d;
        assign o_rs_busy[k]                          = rs_b;
    end
endmodule
